vga_sync_receiver: RTL
======================

# vga_sync_receiver

Recovers pixel coordinates and timing lock from a VGA hsync/vsync pair, i.e. the receiving end of the VGA signal generator's horizontal/vertical counter chain. It samples the sync lines on pixel-enable cycles, measures line and frame lengths, runs a lock state machine against the nominal 640x480 timing, and outputs x/y position plus active-video while locked. It serves as an on-chip checker/loopback monitor for the generator and as the front end for any future capture path.

## Interface
- H_TOTAL, 800, en-cycles per line
- V_TOTAL, 525, hsync assertions per frame
- H_OFFSET, 144, h_cnt value of first active pixel (H_SYNC+H_BP)
- V_OFFSET, 35, v_cnt value of first active line (V_SYNC+V_BP)
- H_ACTIVE, 640; V_ACTIVE, 480, active pixels / lines
- SYNC_POL, 0, asserted level of hsync and vsync (0 = active-low)

- clk  in  1  system clock, single clock domain
- rst  in  1  reset, synchronous and active-high
- en  in  1  pixel-clock enable; all state advances only when en=1
- hsync, vsync  in  1  sync inputs, same clock domain as clk, change only on en cycles
- x_pos, y_pos  out  10  active-area coordinate, 0 outside active area
- active_video  out  1  high when locked and inside active window
- locked  out  1  lock FSM in LOCKED
- frame_start  out  1  one-cycle pulse per vsync assertion while LOCKED
- sync_err  out  1  one-cycle pulse on any timing mismatch in CHECK or LOCKED
- h_total_meas, v_total_meas  out  10  last measured line length / frame length

## Operation
- Edge detect: hs_q/vs_q hold previous sampled level (updated on en cycles). Assertion edge = input at SYNC_POL and q not at SYNC_POL, evaluated on en cycles only. Reset loads hs_q/vs_q to the asserted level, so a sync held asserted through reset produces no edge.
- h_cnt (10 b): on hsync edge -> 0, h_total_meas <= h_cnt+1; else on en -> h_cnt+1, saturating at 1023.
- v_cnt (10 b): on hsync edge -> v_cnt+1 (sat. 1023). On vsync edge -> 0, v_total_meas <= v_cnt + (hsync edge same cycle ? 1 : 0); a coincident hsync edge counts toward the ending frame.
- hs_seen flag: set on first hsync edge after reset.
- FSM states SEARCH, CHECK, LOCKED; reset -> SEARCH.
  - SEARCH -> CHECK on vsync edge with hs_seen=1. No mismatch checks in SEARCH.
  - CHECK -> LOCKED on vsync edge when frame length = V_TOTAL and no mismatch since entering CHECK.
  - CHECK/LOCKED -> SEARCH on mismatch, with sync_err pulse.
- Mismatch: hsync edge with h_cnt+1 != H_TOTAL; h_cnt = H_TOTAL without edge (line too long, flagged that cycle); vsync edge with frame length != V_TOTAL; v_cnt = V_TOTAL+1 (frame too long).
- active_video = locked and H_OFFSET <= h_cnt < H_OFFSET+H_ACTIVE and V_OFFSET <= v_cnt < V_OFFSET+V_ACTIVE. x_pos = h_cnt-H_OFFSET, y_pos = v_cnt-V_OFFSET when active, else 0. These three are combinational from registered state.
- en=0: all registers hold, no edges detected, no pulses.

## Timing
- Reset (synchronous, active-high): every output 0 the cycle after rst sampled high; counters, measurements and hs_seen 0; state SEARCH. rst wins over en and edges.
- Sync edge on en cycle k: h_cnt/v_cnt/measurements updated at k+1.
- locked, frame_start and sync_err are registered: each changes, or pulses high for exactly one clk, at cycle k+1 after the triggering edge or mismatch at cycle k.
- Lock latency from clean stimulus after reset: locked rises one clock after the 2nd vsync edge (first edge enters CHECK, second completes a checked frame).
- frame_start does not pulse on the edge that enters LOCKED; it pulses on every following vsync edge while LOCKED.
- Mismatch in LOCKED: locked falls next cycle. Relock needs a fresh SEARCH->CHECK->LOCKED sequence.

## Test plan
- Nominal 800x525 stimulus, en=1 every cycle, defaults: locked rises 1 clk after 2nd vsync edge; h_total_meas=800, v_total_meas=525; per line active_video high 640 cycles, x 0..639; y 0..479; one frame_start per subsequent frame.
- en asserted every other cycle with same stimulus: identical measured values and lock point in en-cycles; all outputs hold on en=0 cycles.
- While locked, inject one 799-cycle line: sync_err pulse 1 clk, locked low next cycle, relocks 1 clk after the 2nd following vsync edge.
- While locked, hold hsync deasserted: sync_err when h_cnt reaches 800, locked drops; h_total_meas keeps 800.
- hsync and vsync edges forced coincident on one en cycle: v_total_meas=525, lock unaffected.
- Reset pulse mid-frame while locked, with hsync held asserted across reset: all outputs 0 next cycle, no edge counted on release, relock only after full sequence.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// Recovers x/y position, active-video and timing lock from a VGA hsync/vsync pair.
// Line/frame lengths are measured on pixel-enable cycles and checked against nominal timing.
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_OFFSET = 144,
    parameter int unsigned V_OFFSET = 35,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       active_video,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] h_total_meas,
    output logic [9:0] v_total_meas
);

    localparam logic [9:0]  H_TOT  = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
    localparam logic [9:0]  V_OVER = 10'(V_TOTAL + 1);
    localparam logic [9:0]  H_OFF  = 10'(H_OFFSET);
    localparam logic [9:0]  V_OFF  = 10'(V_OFFSET);
    localparam logic [10:0] H_END  = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [10:0] V_END  = 11'(V_OFFSET + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state;
    state_t      state_next;
    logic        hs_q;
    logic        vs_q;
    logic        hs_edge;
    logic        vs_edge;
    logic        hs_seen;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_len;
    logic [10:0] frame_len;
    logic        mismatch;
    logic        frame_start_next;
    logic        sync_err_next;
    logic        h_win;
    logic        v_win;

    assign hs_edge = en && (hsync == SYNC_POL) && (hs_q != SYNC_POL);
    assign vs_edge = en && (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    assign h_len   = {1'b0, h_cnt} + 11'd1;
    // A coincident hsync edge still belongs to the frame that is ending.
    assign frame_len = {1'b0, v_cnt} + {10'd0, hs_edge};

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q         <= SYNC_POL;
            vs_q         <= SYNC_POL;
            h_cnt        <= '0;
            v_cnt        <= '0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            hs_seen      <= 1'b0;
        end else if (en) begin
            hs_q <= hsync;
            vs_q <= vsync;
            if (hs_edge) begin
                h_cnt        <= '0;
                h_total_meas <= h_len[10] ? '1 : h_len[9:0];
                hs_seen      <= 1'b1;
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (vs_edge) begin
                v_cnt        <= '0;
                v_total_meas <= frame_len[10] ? '1 : frame_len[9:0];
            end else if (hs_edge && (v_cnt != '1)) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        mismatch = 1'b0;
        if (en) begin
            if (hs_edge && (h_len != {1'b0, H_TOT}))
                mismatch = 1'b1;
            if (!hs_edge && (h_cnt == H_TOT))
                mismatch = 1'b1;
            if (vs_edge && (frame_len != {1'b0, V_TOT}))
                mismatch = 1'b1;
            if (v_cnt == V_OVER)
                mismatch = 1'b1;
        end
    end

    // State register, with the registered pulse outputs alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_next;
            frame_start <= frame_start_next;
            sync_err    <= sync_err_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH: if (vs_edge && hs_seen) state_next = CHECK;
            CHECK: begin
                if (mismatch)     state_next = SEARCH;
                else if (vs_edge) state_next = LOCKED;
            end
            LOCKED: if (mismatch) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        frame_start_next = (state == LOCKED) && vs_edge && !mismatch;
        sync_err_next    = (state != SEARCH) && mismatch;
        locked           = (state == LOCKED);
        h_win            = (h_cnt >= H_OFF) && ({1'b0, h_cnt} < H_END);
        v_win            = (v_cnt >= V_OFF) && ({1'b0, v_cnt} < V_END);
        active_video     = locked && h_win && v_win;
        x_pos            = active_video ? (h_cnt - H_OFF) : '0;
        y_pos            = active_video ? (v_cnt - V_OFF) : '0;
    end

endmodule
